div_result_queue: RTL and testbench
===================================

// Module: div_result_queue
// PURPOSE
//  Downstream stage of the SRT divider datapath/control pair. Grants launch credit to the divider
//  controller, captures each finished quotient/remainder, and queues results in a DEPTH-entry FIFO
//  that a consumer drains with valid/ready. Handles divide-by-zero tagging and flushes cleanly
//  while a division is still in flight.
// PARAMETERS
//  PARALLELISM  32  operand/result width, same value as the divider datapath
//  DEPTH        4   FIFO entries; power of two, >=2
// PORTS
//  clk           in   1            single clock, rising edge
//  rst_n         in   1            reset, synchronous, active-low
//  flush         in   1            discard queued results and the in-flight division's result
//  launch        in   1            divider controller starts a division (honoured only if launch_ok)
//  launch_ok     out  1            credit available: no division pending, no drop pending, count<DEPTH
//  res_valid     in   1            one-cycle pulse: divider quotient/remainder are final
//  res_quotient  in   PARALLELISM  divider quotient output
//  res_reminder  in   PARALLELISM  divider remainder output
//  res_dividend  in   PARALLELISM  original dividend of the pending operation
//  res_divzero   in   1            divisor of the pending operation was zero
//  out_valid     out  1            head entry available
//  out_ready     in   1            consumer accepts head entry
//  out_quotient  out  PARALLELISM  head quotient; 0 when out_valid=0
//  out_reminder  out  PARALLELISM  head remainder; 0 when out_valid=0
//  out_divzero   out  1            head divide-by-zero tag; 0 when out_valid=0
//  err_protocol  out  1            sticky: launch while !launch_ok, or res_valid with nothing pending
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): FIFO empty, count=0, pending=0, drop=0, err_protocol=0,
//    out_*=0, launch_ok=1. Reset mid-division abandons it; a later res_valid is a protocol error.
//  - State: count (clog2(DEPTH)+1 bits), pending (1 bit), drop (1 bit), rd/wr pointers wrapping mod DEPTH.
//  - launch_ok comes from registered state only. launch && launch_ok -> pending<=1 next cycle.
//    launch && !launch_ok -> ignored, err_protocol<=1.
//  - res_valid && pending && !drop -> push entry, pending<=0. The slot was reserved at launch,
//    so the push never overflows.
//  - res_valid && pending && drop -> result discarded, pending<=0, drop<=0.
//  - res_valid && !pending -> discarded, err_protocol<=1.
//  - Pop: out_valid && out_ready. The head entry leaves; the next entry shows on out_* the
//    following cycle. Push and pop in the same cycle: count unchanged.
//  - Latency: res_valid at cycle N -> out_valid=1 at N+1 (FIFO was empty); out_* are registered.
//  - flush (priority over push/pop): count<=0, pointers<=0, out_valid<=0.
//    A same-cycle res_valid is discarded.
//    If pending && !res_valid -> drop<=1, pending stays 1.
//    A same-cycle launch is evaluated against the pre-flush launch_ok.
//  - Full: count==DEPTH -> launch_ok=0. Empty: out_valid=0 and out_ready is ignored.
//  - Divider is non-interruptible, so at most one division is outstanding. launch_ok stays low
//    from launch until the matching res_valid, including the drop case.
// CONFIGURATION
//  DIV_BY_ZERO_FIX_EN defined: an entry pushed with res_divzero=1 stores quotient={PARALLELISM{1'b1}}
//    and remainder=res_dividend; out_divzero=1.
//  Not defined: raw res_quotient/res_reminder are stored unchanged; out_divzero still tags the entry.
// STRUCTURE
//  - Package div_pkg:
//    - typedef struct packed div_result_t {quotient, reminder, divzero} sized by PARALLELISM
//    - localparam DIV_QUEUE_DEPTH_DEFAULT=4
//  - Sub-module div_result_fifo: DEPTH x div_result_t register array with wr/rd pointers,
//    write/read enables, clear.
//  - Credit/pending/drop/error logic and the DIV_BY_ZERO_FIX_EN mux live in the top module.
// TESTING
//  1. Basic: launch; res_valid with q=7, r=2 -> out_valid next cycle, out_quotient=7,
//     out_reminder=2; out_ready=1 -> out_valid=0.
//  2. Fill: 4 launch/res_valid pairs with out_ready=0 -> launch_ok=0 at count=4.
//     One pop -> launch_ok=1 next cycle; entries drain in push order.
//  3. Flush in flight: launch; flush 3 cycles later -> drop=1, launch_ok=0.
//     res_valid (q=99) discarded. launch_ok=1 the cycle after; out_valid stays 0.
//  4. Div by zero, res_divzero=1, dividend=0x1234, res_q=0xDEAD:
//     with macro -> out_quotient=0xFFFFFFFF, out_reminder=0x1234;
//     without macro -> out_quotient=0xDEAD; out_divzero=1 in both.
//  5. Protocol: res_valid with pending=0, or launch while pending -> err_protocol=1 and holds
//     until rst_n=0; FIFO contents unchanged.
//  6. Simultaneous push+pop at count=2 -> count stays 2, order preserved.
//     Reset asserted mid-queue -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the SRT divider result queue.
package div_pkg;

    localparam int DIV_PARALLELISM         = 32;
    localparam int DIV_QUEUE_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [DIV_PARALLELISM-1:0] quotient;
        logic [DIV_PARALLELISM-1:0] reminder;
        logic                       divzero;
    } div_result_t;

endpackage

// File: rtl/div_result_fifo.sv
// DEPTH-entry result FIFO with clear; head reads as zero when empty.
module div_result_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = DIV_QUEUE_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr_en,
    input  div_result_t   wr_data,
    input  logic          rd_en,
    output div_result_t   rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] count
);

    div_result_t   mem_q [DEPTH];
    div_result_t   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

endmodule

// File: rtl/div_result_queue.sv
// Divider result queue: launch credit, result capture, drop-on-flush, FIFO drain.
// Optional macro DIV_BY_ZERO_FIX_EN: divide-by-zero entries store all-ones / dividend.
module div_result_queue
    import div_pkg::*;
#(
    parameter int PARALLELISM = DIV_PARALLELISM,
    parameter int DEPTH       = DIV_QUEUE_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   launch,
    output logic                   launch_ok,
    input  logic                   res_valid,
    input  logic [PARALLELISM-1:0] res_quotient,
    input  logic [PARALLELISM-1:0] res_reminder,
    input  logic [PARALLELISM-1:0] res_dividend,
    input  logic                   res_divzero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PARALLELISM-1:0] out_quotient,
    output logic [PARALLELISM-1:0] out_reminder,
    output logic                   out_divzero,
    output logic                   err_protocol
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          pending_q, pending_d;
    logic          drop_q, drop_d;
    logic          err_q, err_d;
    logic [CW-1:0] count;
    logic          push, pop;
    div_result_t   wr_data;
    div_result_t   head;

    assign launch_ok = !pending_q && !drop_q && (count != CW'(DEPTH));

    always_comb begin
        wr_data.divzero = res_divzero;
`ifdef DIV_BY_ZERO_FIX_EN
        if (res_divzero) begin
            wr_data.quotient = '1;
            wr_data.reminder = res_dividend;
        end else begin
            wr_data.quotient = res_quotient;
            wr_data.reminder = res_reminder;
        end
`else
        wr_data.quotient = res_quotient;
        wr_data.reminder = res_reminder;
`endif
    end

`ifndef DIV_BY_ZERO_FIX_EN
    logic unused_dividend;
    assign unused_dividend = ^res_dividend;
`endif

    assign push = res_valid && pending_q && !drop_q && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        pending_d = pending_q;
        drop_d    = drop_q;
        err_d     = err_q;
        if (res_valid && pending_q) begin
            pending_d = 1'b0;
            drop_d    = 1'b0;
        end else if (flush && pending_q) begin
            drop_d = 1'b1;
        end
        // Launch is judged against the pre-flush credit.
        if (launch && launch_ok) begin
            pending_d = 1'b1;
        end
        if (launch && !launch_ok) begin
            err_d = 1'b1;
        end
        if (res_valid && !pending_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

    div_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .wr_en    (push),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .rd_valid (out_valid),
        .count    (count)
    );

    assign out_quotient = head.quotient;
    assign out_reminder = head.reminder;
    assign out_divzero  = head.divzero;
    assign err_protocol = err_q;

endmodule

// File: tb/tb_div_result_queue.sv
// Directed self-checking bench for div_result_queue.
module tb_div_result_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        launch = 1'b0;
    logic        launch_ok;
    logic        res_valid = 1'b0;
    logic [31:0] res_quotient = '0;
    logic [31:0] res_reminder = '0;
    logic [31:0] res_dividend = '0;
    logic        res_divzero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_quotient;
    logic [31:0] out_reminder;
    logic        out_divzero;
    logic        err_protocol;

    int checks = 0;
    int errors = 0;

    div_result_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .launch       (launch),
        .launch_ok    (launch_ok),
        .res_valid    (res_valid),
        .res_quotient (res_quotient),
        .res_reminder (res_reminder),
        .res_dividend (res_dividend),
        .res_divzero  (res_divzero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_reminder (out_reminder),
        .out_divzero  (out_divzero),
        .err_protocol (err_protocol)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic do_launch();
        launch = 1'b1;
        cyc();
        launch = 1'b0;
    endtask

    task automatic do_result(input logic [31:0] q, input logic [31:0] r);
        res_valid    = 1'b1;
        res_quotient = q;
        res_reminder = r;
        cyc();
        res_valid = 1'b0;
    endtask

    task automatic do_pop();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (launch_ok !== 1'b1) begin errors++; $display("FAIL reset_launch_ok: got %b want 1", launch_ok); end
        checks++; if (err_protocol !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_protocol); end
        checks++; if (out_quotient !== 32'd0) begin errors++; $display("FAIL reset_q: got %h want 0", out_quotient); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_launch();
        checks++; if (launch_ok !== 1'b0) begin errors++; $display("FAIL basic_credit: got %b want 0", launch_ok); end
        do_result(32'd7, 32'd2);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (out_quotient !== 32'd7) begin errors++; $display("FAIL basic_q: got %h want 7", out_quotient); end
        checks++; if (out_reminder !== 32'd2) begin errors++; $display("FAIL basic_r: got %h want 2", out_reminder); end
        checks++; if (out_divzero !== 1'b0) begin errors++; $display("FAIL basic_dz: got %b want 0", out_divzero); end
        checks++; if (launch_ok !== 1'b1) begin errors++; $display("FAIL basic_credit_back: got %b want 1", launch_ok); end
        do_pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %b want 0", out_valid); end
        checks++; if (out_quotient !== 32'd0) begin errors++; $display("FAIL basic_pop_q: got %h want 0", out_quotient); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            do_launch();
            do_result(32'd10 + 32'(i), 32'(i));
            if (i < 3) begin
                checks++; if (launch_ok !== 1'b1) begin errors++; $display("FAIL fill_credit%0d: got %b want 1", i, launch_ok); end
            end
        end
        checks++; if (launch_ok !== 1'b0) begin errors++; $display("FAIL fill_full: got %b want 0", launch_ok); end
        checks++; if (out_quotient !== 32'd10) begin errors++; $display("FAIL fill_head: got %h want a", out_quotient); end
        do_pop();
        checks++; if (launch_ok !== 1'b1) begin errors++; $display("FAIL fill_credit_pop: got %b want 1", launch_ok); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (out_quotient !== 32'd10 + 32'(i)) begin errors++; $display("FAIL fill_order_q%0d: got %h want %h", i, out_quotient, 32'd10 + 32'(i)); end
            checks++; if (out_reminder !== 32'(i)) begin errors++; $display("FAIL fill_order_r%0d: got %h want %h", i, out_reminder, 32'(i)); end
            do_pop();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_flush_in_flight();
        do_launch();
        do_result(32'd5, 32'd1);
        do_launch();
        cyc();
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++; if (launch_ok !== 1'b0) begin errors++; $display("FAIL flush_drop_credit: got %b want 0", launch_ok); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_cleared: got %b want 0", out_valid); end
        do_result(32'd99, 32'd0);
        checks++; if (launch_ok !== 1'b1) begin errors++; $display("FAIL flush_credit_back: got %b want 1", launch_ok); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got %b want 0", out_valid); end
        checks++; if (err_protocol !== 1'b0) begin errors++; $display("FAIL flush_err: got %b want 0", err_protocol); end
    endtask

    task automatic test_divzero();
        logic [31:0] exp_q;
        logic [31:0] exp_r;
`ifdef DIV_BY_ZERO_FIX_EN
        exp_q = 32'hFFFF_FFFF;
        exp_r = 32'h0000_1234;
`else
        exp_q = 32'h0000_DEAD;
        exp_r = 32'h0000_0055;
`endif
        do_launch();
        res_divzero  = 1'b1;
        res_dividend = 32'h1234;
        do_result(32'hDEAD, 32'h55);
        res_divzero  = 1'b0;
        res_dividend = '0;
        checks++; if (out_quotient !== exp_q) begin errors++; $display("FAIL dz_q: got %h want %h", out_quotient, exp_q); end
        checks++; if (out_reminder !== exp_r) begin errors++; $display("FAIL dz_r: got %h want %h", out_reminder, exp_r); end
        checks++; if (out_divzero !== 1'b1) begin errors++; $display("FAIL dz_tag: got %b want 1", out_divzero); end
        do_pop();
    endtask

    task automatic test_protocol();
        do_reset();
        do_launch();
        do_result(32'h42, 32'h3);
        checks++; if (err_protocol !== 1'b0) begin errors++; $display("FAIL proto_clean: got %b want 0", err_protocol); end
        do_result(32'h77, 32'h7);
        checks++; if (err_protocol !== 1'b1) begin errors++; $display("FAIL proto_stray_res: got %b want 1", err_protocol); end
        checks++; if (out_quotient !== 32'h42) begin errors++; $display("FAIL proto_head: got %h want 42", out_quotient); end
        do_pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL proto_no_push: got %b want 0", out_valid); end
        do_reset();
        checks++; if (err_protocol !== 1'b0) begin errors++; $display("FAIL proto_reset: got %b want 0", err_protocol); end
        do_launch();
        do_launch();
        checks++; if (err_protocol !== 1'b1) begin errors++; $display("FAIL proto_double_launch: got %b want 1", err_protocol); end
        checks++; if (launch_ok !== 1'b0) begin errors++; $display("FAIL proto_still_pending: got %b want 0", launch_ok); end
        do_result(32'h11, 32'h1);
        cyc();
        checks++; if (err_protocol !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b want 1", err_protocol); end
        checks++; if (out_quotient !== 32'h11) begin errors++; $display("FAIL proto_single: got %h want 11", out_quotient); end
        do_pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL proto_one_entry: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_launch();
        do_result(32'd1, 32'd0);
        do_launch();
        do_result(32'd2, 32'd0);
        do_launch();
        out_ready = 1'b1;
        do_result(32'd3, 32'd0);
        out_ready = 1'b0;
        checks++; if (out_quotient !== 32'd2) begin errors++; $display("FAIL b2b_head: got %h want 2", out_quotient); end
        do_pop();
        checks++; if (out_quotient !== 32'd3) begin errors++; $display("FAIL b2b_next: got %h want 3", out_quotient); end
        do_pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_count: got %b want 0", out_valid); end
        do_launch();
        do_result(32'd8, 32'd4);
        do_launch();
        do_result(32'd9, 32'd5);
        do_launch();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        checks++; if (out_quotient !== 32'd0) begin errors++; $display("FAIL rst_mid_q: got %h want 0", out_quotient); end
        checks++; if (out_reminder !== 32'd0) begin errors++; $display("FAIL rst_mid_r: got %h want 0", out_reminder); end
        checks++; if (launch_ok !== 1'b1) begin errors++; $display("FAIL rst_mid_credit: got %b want 1", launch_ok); end
        do_result(32'd1, 32'd1);
        checks++; if (err_protocol !== 1'b1) begin errors++; $display("FAIL rst_mid_stray: got %b want 1", err_protocol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_flush_in_flight();
        test_divzero();
        test_protocol();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
